// File: rtl/seq_checker.sv
// ----------------------------------------------------------------------------
// seq_checker
//
// Receive-side checker for the five-state code sequence
//    000 -> 010 -> 011 -> 101 -> 110 -> 000 -> ...
//
// One 3-bit code is sampled on every cycle where in_valid is high. The checker
// hunts for a legal code, then verifies a run of correct successors. After that
// run it declares lock and tracks the sequence from then on. While locked, each
// deviation from the expected code produces a one-cycle err_pulse and bumps a
// saturating error counter. A short burst of consecutive deviations drops the
// checker back to hunting.
//
// Parameters
//    LOCK_CNT   consecutive correct successors in VERIFY needed to lock (>=1)
//    LOSS_CNT   consecutive mismatches while locked before returning to HUNT (>=1)
//    ERR_W      width of err_count
//
// Ports
//    clk        in   1      clock, rising edge
//    rst        in   1      asynchronous, active-high reset
//    in_valid   in   1      in_code is sampled this cycle
//    in_code    in   3      received sequence code
//    clr_err    in   1      synchronous clear of err_count
//    locked     out  1      registered, high in LOCKED and SLIP
//    err_pulse  out  1      registered one-cycle pulse per mismatch counted while locked
//    exp_code   out  3      registered expected next code
//    err_count  out  ERR_W  saturating count of mismatches seen while locked
// ----------------------------------------------------------------------------
module seq_checker #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_code,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [2:0]       exp_code,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [1:0] SLIP   = 2'd3;

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    // The counters are compared against "one short of the target". A hit
    // therefore means that this correct code (or this miss) completes the run.
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

    logic [1:0]         stateQ, stateD;
    logic [2:0]         expQ, expD;
    logic [MATCH_W-1:0] matchQ, matchD;
    logic [MISS_W-1:0]  missQ, missD;
    logic [ERR_W-1:0]   errCountQ, errCountD;
    logic               errPulseQ, errPulseD;
    logic               lockedQ, lockedD;

    logic               codeLegal;
    logic               codeHit;
    logic               countErr;

    // Successor of a code in the sequence. The illegal codes map to 000, but
    // callers only ever feed this function legal codes.
    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            3'b000:  succ = 3'b010;
            3'b010:  succ = 3'b011;
            3'b011:  succ = 3'b101;
            3'b101:  succ = 3'b110;
            default: succ = 3'b000;
        endcase
    endfunction

    function automatic logic isLegal(input logic [2:0] c);
        isLegal = (c == 3'b000) || (c == 3'b010) || (c == 3'b011) ||
                  (c == 3'b101) || (c == 3'b110);
    endfunction

    assign codeLegal = isLegal(in_code);
    // exp is always a legal code, so an illegal input can never hit.
    assign codeHit   = (in_code == expQ);
    assign countErr  = in_valid && ((stateQ == LOCKED) || (stateQ == SLIP)) && !codeHit;

    // Next-state logic for the acquisition / tracking FSM and its counters.
    always_comb begin
        stateD = stateQ;
        expD   = expQ;
        matchD = matchQ;
        missD  = missQ;

        if (in_valid) begin
            case (stateQ)
                HUNT: begin
                    if (codeLegal) begin
                        stateD = VERIFY;
                        expD   = succ(in_code);
                        matchD = '0;
                    end
                end
                VERIFY: begin
                    if (codeHit) begin
                        expD = succ(expQ);
                        if (matchQ == MATCH_LAST) begin
                            stateD = LOCKED;
                            matchD = '0;
                        end else begin
                            matchD = matchQ + 1'b1;
                        end
                    end else if (codeLegal) begin
                        // A legal code that breaks the run re-seeds the search from here.
                        expD   = succ(in_code);
                        matchD = '0;
                    end else begin
                        stateD = HUNT;
                        matchD = '0;
                    end
                end
                LOCKED: begin
                    // On a mismatch the expected code still advances (flywheel).
                    // A single corrupted code therefore does not desynchronise tracking.
                    expD = succ(expQ);
                    if (!codeHit) begin
                        if (LOSS_CNT == 1) begin
                            stateD = HUNT;
                            missD  = '0;
                        end else begin
                            stateD = SLIP;
                            missD  = MISS_W'(1);
                        end
                    end
                end
                default: begin // SLIP
                    expD = succ(expQ);
                    if (codeHit) begin
                        stateD = LOCKED;
                        missD  = '0;
                    end else if (missQ == MISS_LAST) begin
                        stateD = HUNT;
                        missD  = '0;
                    end else begin
                        missD = missQ + 1'b1;
                    end
                end
            endcase
        end
    end

    // A counted error together with clr_err leaves the counter at one: the clear
    // happens first, then the count. The counter sticks at all-ones.
    always_comb begin
        errCountD = errCountQ;
        if (countErr) begin
            if (clr_err) begin
                errCountD = ERR_W'(1);
            end else if (errCountQ != ERR_MAX) begin
                errCountD = errCountQ + 1'b1;
            end
        end else if (clr_err) begin
            errCountD = '0;
        end
    end

    assign errPulseD = countErr;
    assign lockedD   = (stateD == LOCKED) || (stateD == SLIP);

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= HUNT;
            expQ      <= 3'b000;
            matchQ    <= '0;
            missQ     <= '0;
            errCountQ <= '0;
            errPulseQ <= 1'b0;
            lockedQ   <= 1'b0;
        end else begin
            stateQ    <= stateD;
            expQ      <= expD;
            matchQ    <= matchD;
            missQ     <= missD;
            errCountQ <= errCountD;
            errPulseQ <= errPulseD;
            lockedQ   <= lockedD;
        end
    end

    assign locked    = lockedQ;
    assign err_pulse = errPulseQ;
    assign exp_code  = expQ;
    assign err_count = errCountQ;

endmodule

// File: tb/tb_seq_checker.sv
// ----------------------------------------------------------------------------
// tb_seq_checker
//
// Directed bench for seq_checker. It uses LOCK_CNT=3, LOSS_CNT=2 and ERR_W=2,
// so saturation of the error counter is reachable. Inputs change 1 ns after a
// rising edge. Outputs are checked 1 ns after the edge that sampled the input.
// ----------------------------------------------------------------------------
module tb_seq_checker;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic [2:0] inCode;
    logic       clrErr;
    logic       locked;
    logic       errPulse;
    logic [2:0] expCode;
    logic [1:0] errCount;

    int errors;
    int checks;

    logic [2:0] seqCodes [5];
    logic [2:0] expModel;

    seq_checker #(
        .LOCK_CNT(3),
        .LOSS_CNT(2),
        .ERR_W   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inValid),
        .in_code  (inCode),
        .clr_err  (clrErr),
        .locked   (locked),
        .err_pulse(errPulse),
        .exp_code (expCode),
        .err_count(errCount)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference successor function, written out directly from the code table.
    function automatic logic [2:0] refSucc(input logic [2:0] c);
        case (c)
            3'b000:  refSucc = 3'b010;
            3'b010:  refSucc = 3'b011;
            3'b011:  refSucc = 3'b101;
            3'b101:  refSucc = 3'b110;
            3'b110:  refSucc = 3'b000;
            default: refSucc = 3'bxxx;
        endcase
    endfunction

    // Drive one cycle of inputs, let the DUT clock them in, then settle.
    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic clr);
        inValid = v;
        inCode  = c;
        clrErr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic l, input logic p,
                            input logic [2:0] e, input logic [1:0] c);
        checkOutput({tag, ".locked"},    {7'd0, locked},   {7'd0, l});
        checkOutput({tag, ".err_pulse"}, {7'd0, errPulse}, {7'd0, p});
        checkOutput({tag, ".exp_code"},  {5'd0, expCode},  {5'd0, e});
        checkOutput({tag, ".err_count"}, {6'd0, errCount}, {6'd0, c});
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        inValid = 1'b0;
        inCode  = 3'b000;
        clrErr  = 1'b0;
        seqCodes[0] = 3'b110;
        seqCodes[1] = 3'b000;
        seqCodes[2] = 3'b010;
        seqCodes[3] = 3'b011;
        seqCodes[4] = 3'b101;

        // Reset state.
        @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 1'b0, 3'b000, 2'd0);
        rst = 1'b0;

        // T1: acquire lock from 000,010,011,101.
        $display("[TB] T1 lock");
        applyStimulus(1'b1, 3'b000, 1'b0);
        checkAll("t1_000", 1'b0, 1'b0, 3'b010, 2'd0);
        applyStimulus(1'b1, 3'b010, 1'b0);
        checkAll("t1_010", 1'b0, 1'b0, 3'b011, 2'd0);
        applyStimulus(1'b1, 3'b011, 1'b0);
        checkAll("t1_011", 1'b0, 1'b0, 3'b101, 2'd0);
        applyStimulus(1'b1, 3'b101, 1'b0);
        checkAll("t1_101", 1'b1, 1'b0, 3'b110, 2'd0);

        // T2: ten full periods through the wrap, with idle gaps.
        $display("[TB] T2 wrap and gaps");
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 5; i++) begin
                applyStimulus(1'b1, seqCodes[i], 1'b0);
                checkAll("t2_code", 1'b1, 1'b0, refSucc(seqCodes[i]), 2'd0);
                if (i % 2 == 1) begin
                    // A garbage code with in_valid low must be ignored.
                    applyStimulus(1'b0, 3'b111, 1'b0);
                    checkAll("t2_gap", 1'b1, 1'b0, refSucc(seqCodes[i]), 2'd0);
                end
            end
        end

        // T3: single error, 111 in place of 110, then 000 resyncs.
        $display("[TB] T3 single error");
        applyStimulus(1'b1, 3'b111, 1'b0);
        checkAll("t3_err", 1'b1, 1'b1, 3'b000, 2'd1);
        applyStimulus(1'b1, 3'b000, 1'b0);
        checkAll("t3_resync", 1'b1, 1'b0, 3'b010, 2'd1);

        // Clear on its own, while idle.
        applyStimulus(1'b0, 3'b000, 1'b1);
        checkAll("clr_alone", 1'b1, 1'b0, 3'b010, 2'd0);

        // T4: two consecutive mismatches lose lock. exp holds after the flywheel step.
        $display("[TB] T4 loss");
        applyStimulus(1'b1, 3'b111, 1'b0);
        checkAll("t4_miss1", 1'b1, 1'b1, 3'b011, 2'd1);
        applyStimulus(1'b1, 3'b001, 1'b0);
        checkAll("t4_miss2", 1'b0, 1'b1, 3'b101, 2'd2);
        applyStimulus(1'b1, 3'b010, 1'b0);
        checkAll("t4_seed", 1'b0, 1'b0, 3'b011, 2'd2);
        applyStimulus(1'b1, 3'b011, 1'b0);
        checkAll("t4_m1", 1'b0, 1'b0, 3'b101, 2'd2);
        applyStimulus(1'b1, 3'b101, 1'b0);
        checkAll("t4_m2", 1'b0, 1'b0, 3'b110, 2'd2);
        applyStimulus(1'b1, 3'b110, 1'b0);
        checkAll("t4_relock", 1'b1, 1'b0, 3'b000, 2'd2);

        // T5: five isolated errors saturate a 2-bit counter at 3, and each one still pulses.
        $display("[TB] T5 saturation and clear");
        applyStimulus(1'b0, 3'b000, 1'b1);
        checkAll("t5_clr", 1'b1, 1'b0, 3'b000, 2'd0);
        expModel = 3'b000;
        for (int k = 1; k <= 5; k++) begin
            expModel = refSucc(expModel);
            applyStimulus(1'b1, 3'b111, 1'b0);
            checkAll("t5_err", 1'b1, 1'b1, expModel, (k > 3) ? 2'd3 : 2'(k));
            applyStimulus(1'b1, expModel, 1'b0);
            expModel = refSucc(expModel);
            checkAll("t5_ok", 1'b1, 1'b0, expModel, (k > 3) ? 2'd3 : 2'(k));
        end
        // expModel is 000 here. A clear together with a counted error leaves the count at one.
        applyStimulus(1'b1, 3'b100, 1'b1);
        checkAll("t5_clr_err", 1'b1, 1'b1, 3'b010, 2'd1);
        applyStimulus(1'b1, 3'b010, 1'b0);
        checkAll("t5_back", 1'b1, 1'b0, 3'b011, 2'd1);

        // T6: asynchronous reset between edges while locked.
        $display("[TB] T6 reset mid-stream");
        #2;
        rst = 1'b1;
        #1;
        checkAll("t6_async", 1'b0, 1'b0, 3'b000, 2'd0);
        applyStimulus(1'b1, 3'b011, 1'b0);
        checkAll("t6_held", 1'b0, 1'b0, 3'b000, 2'd0);
        rst = 1'b0;
        // In HUNT an illegal code is ignored.
        applyStimulus(1'b1, 3'b111, 1'b0);
        checkAll("t6_hunt_ill", 1'b0, 1'b0, 3'b000, 2'd0);
        applyStimulus(1'b1, 3'b011, 1'b0);
        checkAll("t6_seed", 1'b0, 1'b0, 3'b101, 2'd0);
        applyStimulus(1'b1, 3'b101, 1'b0);
        checkAll("t6_m1", 1'b0, 1'b0, 3'b110, 2'd0);
        // A legal mismatch in VERIFY re-seeds and restarts the match count.
        applyStimulus(1'b1, 3'b000, 1'b0);
        checkAll("t6_reseed", 1'b0, 1'b0, 3'b010, 2'd0);
        applyStimulus(1'b1, 3'b010, 1'b0);
        checkAll("t6_r1", 1'b0, 1'b0, 3'b011, 2'd0);
        applyStimulus(1'b1, 3'b011, 1'b0);
        checkAll("t6_r2", 1'b0, 1'b0, 3'b101, 2'd0);
        applyStimulus(1'b1, 3'b101, 1'b0);
        checkAll("t6_relock", 1'b1, 1'b0, 3'b110, 2'd0);
        // An illegal code in VERIFY returns to HUNT, where exp holds.
        applyStimulus(1'b1, 3'b111, 1'b0);
        checkAll("t6_lk_err", 1'b1, 1'b1, 3'b000, 2'd1);
        applyStimulus(1'b1, 3'b111, 1'b0);
        checkAll("t6_lost", 1'b0, 1'b1, 3'b010, 2'd2);
        applyStimulus(1'b1, 3'b110, 1'b0);
        checkAll("t6_vseed", 1'b0, 1'b0, 3'b000, 2'd2);
        applyStimulus(1'b1, 3'b001, 1'b0);
        checkAll("t6_v_ill", 1'b0, 1'b0, 3'b000, 2'd2);
        applyStimulus(1'b1, 3'b000, 1'b0);
        checkAll("t6_v_hunt", 1'b0, 1'b0, 3'b010, 2'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
